// File: rtl/vga_timing_detector.sv
// Sink-side VGA timing recovery: rebuilds h/v counts from incoming syncs, measures line/frame length,
// and qualifies the stream against the configured mode before exposing pixel coordinates.
module vga_timing_detector #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int H_START     = 144,
   parameter int H_ACTIVE    = 640,
   parameter int V_START     = 35,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2,
   parameter int SYNC_LOW    = 1
) (
   input  logic        clk25MHz,
   input  logic        reset_n,
   input  logic        hsync,
   input  logic        vsync,
   output logic [15:0] pixel_x,
   output logic [15:0] pixel_y,
   output logic        active_video,
   output logic [15:0] line_len,
   output logic [15:0] frame_lines,
   output logic        locked,
   output logic        timing_err
);

   // state  | meaning
   // SEARCH | no frame reference yet; waiting for first vsync edge
   // TRACK  | counting consecutive good frames toward lock
   // LOCKED | timing matches mode; pixel coordinates valid
   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic        SYNC_IDLE   = (SYNC_LOW != 0);
   localparam logic [15:0] H_TOTAL_W   = 16'(H_TOTAL);
   localparam logic [15:0] V_TOTAL_W   = 16'(V_TOTAL);
   localparam logic [15:0] H_START_W   = 16'(H_START);
   localparam logic [15:0] H_END_W     = 16'(H_START + H_ACTIVE);
   localparam logic [15:0] V_START_W   = 16'(V_START);
   localparam logic [15:0] V_END_W     = 16'(V_START + V_ACTIVE);
   localparam logic [15:0] H_TIMEOUT_W = 16'(2 * H_TOTAL - 1);
   localparam logic [3:0]  LOCK_W      = 4'(LOCK_FRAMES);

   state_t      state_q, state_d;
   logic        hs_q, vs_q;
   logic [15:0] h_cnt_q, h_cnt_d;
   logic [15:0] v_cnt_q, v_cnt_d;
   logic [15:0] line_len_q, line_len_d;
   logic [15:0] frame_lines_q, frame_lines_d;
   logic [3:0]  good_q, good_d;
   logic        bad_line_q, bad_line_d;
   logic        locked_q, locked_d;
   logic        timing_err_q, timing_err_d;
   logic        active_q, active_d;
   logic [15:0] px_q, px_d;
   logic [15:0] py_q, py_d;

   logic        hs_start, vs_start;
   logic [15:0] h_inc, v_inc;
   logic        line_bad, frame_bad, h_timeout, in_window;

   // Sync polarity is folded in here so everything downstream sees "asserted" as 1.
   assign hs_start = (hsync ^ SYNC_IDLE) & ~(hs_q ^ SYNC_IDLE);
   assign vs_start = (vsync ^ SYNC_IDLE) & ~(vs_q ^ SYNC_IDLE);

   assign h_inc = (h_cnt_q == 16'hFFFF) ? h_cnt_q : h_cnt_q + 16'd1;
   assign v_inc = (v_cnt_q == 16'hFFFF) ? v_cnt_q : v_cnt_q + 16'd1;

   always_comb begin
      h_cnt_d       = h_inc;
      line_len_d    = line_len_q;
      v_cnt_d       = v_cnt_q;
      frame_lines_d = frame_lines_q;
      if (hs_start) begin
         h_cnt_d    = 16'd0;
         line_len_d = h_inc;
      end
      if (hs_start && vs_start) begin
         frame_lines_d = v_inc;
         v_cnt_d       = 16'd0;
      end else if (vs_start) begin
         frame_lines_d = v_cnt_q;
         v_cnt_d       = 16'd0;
      end else if (hs_start) begin
         v_cnt_d = v_inc;
      end
   end

   // A bad line coinciding with vs_start still belongs to the frame that is ending.
   assign line_bad  = hs_start && (h_inc != H_TOTAL_W);
   assign frame_bad = vs_start && ((frame_lines_d != V_TOTAL_W) || bad_line_q || line_bad);
   assign h_timeout = !hs_start && (h_cnt_d == H_TIMEOUT_W);

   always_ff @(posedge clk25MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SEARCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      good_d     = good_q;
      bad_line_d = vs_start ? 1'b0 : (bad_line_q | line_bad);
      if (h_timeout) begin
         state_d = SEARCH;
         good_d  = 4'd0;
      end else begin
         case (state_q)
            SEARCH: begin
               if (vs_start) begin
                  state_d = TRACK;
                  good_d  = 4'd0;
               end
            end
            TRACK: begin
               if (vs_start) begin
                  if (frame_bad) begin
                     good_d = 4'd0;
                  end else begin
                     good_d = good_q + 4'd1;
                     if (good_q + 4'd1 >= LOCK_W) begin
                        state_d = LOCKED;
                     end
                  end
               end
            end
            LOCKED: begin
               if (line_bad || frame_bad) begin
                  state_d = TRACK;
                  good_d  = 4'd0;
               end
            end
            default: begin
               state_d = SEARCH;
               good_d  = 4'd0;
            end
         endcase
      end
   end

   assign in_window = (h_cnt_q >= H_START_W) && (h_cnt_q < H_END_W) &&
                      (v_cnt_q >= V_START_W) && (v_cnt_q < V_END_W);

   always_comb begin
      locked_d     = (state_d == LOCKED);
      timing_err_d = (state_q == LOCKED) && (state_d != LOCKED);
      active_d     = (state_q == LOCKED) && in_window;
      px_d         = active_d ? (h_cnt_q - H_START_W) : 16'd0;
      py_d         = active_d ? (v_cnt_q - V_START_W) : 16'd0;
   end

   always_ff @(posedge clk25MHz or negedge reset_n) begin
      if (!reset_n) begin
         hs_q          <= SYNC_IDLE;
         vs_q          <= SYNC_IDLE;
         h_cnt_q       <= 16'd0;
         v_cnt_q       <= 16'd0;
         line_len_q    <= 16'd0;
         frame_lines_q <= 16'd0;
         good_q        <= 4'd0;
         bad_line_q    <= 1'b0;
         locked_q      <= 1'b0;
         timing_err_q  <= 1'b0;
         active_q      <= 1'b0;
         px_q          <= 16'd0;
         py_q          <= 16'd0;
      end else begin
         hs_q          <= hsync;
         vs_q          <= vsync;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         good_q        <= good_d;
         bad_line_q    <= bad_line_d;
         locked_q      <= locked_d;
         timing_err_q  <= timing_err_d;
         active_q      <= active_d;
         px_q          <= px_d;
         py_q          <= py_d;
      end
   end

   assign pixel_x      = px_q;
   assign pixel_y      = py_q;
   assign active_video = active_q;
   assign line_len     = line_len_q;
   assign frame_lines  = frame_lines_q;
   assign locked       = locked_q;
   assign timing_err   = timing_err_q;

endmodule

// File: tb/tb_vga_timing_detector.sv
// Directed bench for vga_timing_detector on a scaled-down mode (40x20 clocks) so frames stay short.
module tb_vga_timing_detector;

   localparam int HT  = 40;
   localparam int VT  = 20;
   localparam int HST = 8;
   localparam int HA  = 24;
   localparam int VST = 3;
   localparam int VA  = 14;
   localparam int HSW = 4;
   localparam int VSW = 2;

   logic        clk, rst_n, hsync, vsync;
   logic [15:0] pixel_x, pixel_y, line_len, frame_lines;
   logic        active_video, locked, timing_err;

   int tests = 0, fails = 0;
   int err_seen = 0, locked_seen = 0, err_before;
   int hp = 0, vp = 0, ht_mode = HT, stretch_line = -1, short_pending = 0;
   int hs_en = 1, chk_pix = 0, exp_lock = 1, last_h = -1, last_v = -1;

   typedef struct {
      logic        v;
      logic        act;
      logic [15:0] x;
      logic [15:0] y;
   } sb_t;
   sb_t sb_q[$];

   vga_timing_detector #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HST), .H_ACTIVE(HA),
      .V_START(VST), .V_ACTIVE(VA), .LOCK_FRAMES(2), .SYNC_LOW(1)
   ) dut (
      .clk25MHz    (clk),
      .reset_n     (rst_n),
      .hsync       (hsync),
      .vsync       (vsync),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .active_video(active_video),
      .line_len    (line_len),
      .frame_lines (frame_lines),
      .locked      (locked),
      .timing_err  (timing_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (timing_err) err_seen++;
      if (locked) locked_seen++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One pixel clock: retire the scoreboard entry due now, then drive the next generator position.
   task automatic step();
      sb_t  e;
      int   cur_ht, cur_vt;
      logic in_win;
      @(negedge clk);
      if (sb_q.size() >= 2) begin
         e = sb_q.pop_front();
         if (e.v) begin
            chk("sb_active", {31'd0, active_video}, {31'd0, e.act});
            chk("sb_pixel_x", {16'd0, pixel_x}, {16'd0, e.x});
            chk("sb_pixel_y", {16'd0, pixel_y}, {16'd0, e.y});
         end
      end
      hsync  = (hs_en != 0 && hp < HSW) ? 1'b0 : 1'b1;
      vsync  = (vp < VSW) ? 1'b0 : 1'b1;
      last_h = hp;
      last_v = vp;
      in_win = (exp_lock != 0) && hp >= HST && hp < HST + HA && vp >= VST && vp < VST + VA;
      e.v    = (chk_pix != 0);
      e.act  = in_win;
      e.x    = in_win ? 16'(hp - HST) : 16'd0;
      e.y    = in_win ? 16'(vp - VST) : 16'd0;
      sb_q.push_back(e);
      cur_ht = ht_mode + ((vp == stretch_line) ? 1 : 0);
      cur_vt = (short_pending != 0) ? VT - 1 : VT;
      if (hp >= cur_ht - 1) begin
         hp = 0;
         if (vp == stretch_line) stretch_line = -1;
         if (vp >= cur_vt - 1) begin
            vp = 0;
            short_pending = 0;
         end else begin
            vp++;
         end
      end else begin
         hp++;
      end
   endtask

   task automatic run_frames(input int k);
      int n = 0, budget = 0;
      while (n < k && budget < 20000) begin
         step();
         budget++;
         if (last_h == 0 && last_v == 0) n++;
      end
      if (n < k) begin
         tests++;
         fails++;
         $error("FAIL frame_budget: observed %0d frames expected %0d", n, k);
      end
   endtask

   task automatic run_to(input int h, input int v);
      int budget = 0;
      do begin
         step();
         budget++;
      end while (!(last_h == h && last_v == v) && budget < 20000);
      if (!(last_h == h && last_v == v)) begin
         tests++;
         fails++;
         $error("FAIL pos_budget: observed %0d,%0d expected %0d,%0d", last_h, last_v, h, v);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_px"}, {16'd0, pixel_x}, 32'd0);
      chk({tag, "_py"}, {16'd0, pixel_y}, 32'd0);
      chk({tag, "_act"}, {31'd0, active_video}, 32'd0);
      chk({tag, "_len"}, {16'd0, line_len}, 32'd0);
      chk({tag, "_lines"}, {16'd0, frame_lines}, 32'd0);
      chk({tag, "_lock"}, {31'd0, locked}, 32'd0);
      chk({tag, "_err"}, {31'd0, timing_err}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      hsync = 1'b1;
      vsync = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // acquisition: lock after the third vs_start
      run_frames(2);
      step();
      chk("acq_not_yet", {31'd0, locked}, 32'd0);
      run_frames(1);
      step();
      chk("acq_locked", {31'd0, locked}, 32'd1);
      chk("acq_line_len", {16'd0, line_len}, HT);
      chk("acq_frame_lines", {16'd0, frame_lines}, VT);
      chk("acq_no_err", err_seen, 0);

      // one full frame of pixel coordinates through the scoreboard
      chk_pix = 1;
      run_frames(1);
      chk_pix = 0;

      // stretched line while locked
      stretch_line = 5;
      run_to(0, 6);
      step();
      chk("str_err", {31'd0, timing_err}, 32'd1);
      chk("str_unlock", {31'd0, locked}, 32'd0);
      chk("str_len", {16'd0, line_len}, HT + 1);
      step();
      chk("str_err_1cyc", {31'd0, timing_err}, 32'd0);
      run_frames(1);
      step();
      chk("str_relock0", {31'd0, locked}, 32'd0);
      run_frames(1);
      step();
      chk("str_relock1", {31'd0, locked}, 32'd0);
      run_frames(1);
      step();
      chk("str_relock2", {31'd0, locked}, 32'd1);
      chk("str_err_count", err_seen, 1);

      // short frame while locked
      short_pending = 1;
      run_frames(1);
      step();
      chk("short_lines", {16'd0, frame_lines}, VT - 1);
      chk("short_err", {31'd0, timing_err}, 32'd1);
      chk("short_unlock", {31'd0, locked}, 32'd0);
      step();
      chk("short_err_1cyc", {31'd0, timing_err}, 32'd0);
      run_frames(2);
      step();
      chk("short_relock", {31'd0, locked}, 32'd1);

      // hsync stops while locked: timeout at h_cnt = 2*HT-1
      run_to(0, 10);
      hs_en = 0;
      step();
      repeat (2 * HT - 2) step();
      chk("to_still_locked", {31'd0, locked}, 32'd1);
      chk("to_no_err_yet", {31'd0, timing_err}, 32'd0);
      step();
      chk("to_err", {31'd0, timing_err}, 32'd1);
      chk("to_unlock", {31'd0, locked}, 32'd0);
      step();
      chk("to_err_1cyc", {31'd0, timing_err}, 32'd0);
      exp_lock = 0;
      chk_pix  = 1;
      repeat (100) step();
      chk_pix  = 0;

      // wrong line length for ten frames
      hs_en       = 1;
      ht_mode     = 52;
      err_before  = err_seen;
      locked_seen = 0;
      run_frames(10);
      step();
      chk("wm_unlocked", {31'd0, locked}, 32'd0);
      chk("wm_line_len", {16'd0, line_len}, 52);
      chk("wm_frame_lines", {16'd0, frame_lines}, VT);
      ht_mode = HT;
      step();
      chk("wm_never_locked", locked_seen, 0);
      chk("wm_no_err", err_seen, err_before);
      run_frames(2);
      step();
      chk("wm_relock", {31'd0, locked}, 32'd1);

      // asynchronous reset mid-line while locked
      exp_lock = 1;
      run_to(20, 5);
      chk("rst_pre_locked", {31'd0, locked}, 32'd1);
      err_before = err_seen;
      #3 rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      step();
      step();
      chk("rst_held", {31'd0, locked}, 32'd0);
      rst_n = 1'b1;
      run_frames(2);
      step();
      chk("rst_relock_early", {31'd0, locked}, 32'd0);
      run_frames(1);
      step();
      chk("rst_relock", {31'd0, locked}, 32'd1);
      chk("rst_frame_lines", {16'd0, frame_lines}, VT);
      step();
      chk("rst_no_err", err_seen, err_before);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
